// File: rtl/decode_ctrl_pipe.sv
// Registered D->E control decoder with HI/LO multiply/divide support, MDU busy timer and MDU stall.
// Build option ILLEGAL_TRAP_EN: unknown encodings issue as a valid bundle flagged by e_illegal.
module decode_ctrl_pipe #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] instr_d,
  input  logic        valid_d,
  input  logic        stall_in,
  input  logic        flush,
  output logic        stall_out,
  output logic        e_valid,
  output logic        e_reg_write,
  output logic        e_mem_write,
  output logic        e_alu_src,
  output logic        e_branch,
  output logic        e_jump,
  output logic [1:0]  e_reg_dst,
  output logic [1:0]  e_mem2reg,
  output logic [1:0]  e_ext_op,
  output logic [3:0]  e_alu_op,
  output logic [1:0]  e_ls_type,
  output logic [5:0]  e_b_op,
  output logic [1:0]  e_jump_src,
  output logic [2:0]  e_mdu_op,
  output logic        e_hilo_sel,
  output logic        mdu_start,
  output logic        mdu_busy,
  output logic        e_illegal
);

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_write;
    logic       alu_src;
    logic       branch;
    logic       jump;
    logic [1:0] reg_dst;
    logic [1:0] mem2reg;
    logic [1:0] ext_op;
    logic [3:0] alu_op;
    logic [1:0] ls_type;
    logic [5:0] b_op;
    logic [1:0] jump_src;
    logic [2:0] mdu_op;
    logic       hilo_sel;
    logic       illegal;
  } ctrl_t;

  localparam logic [5:0] OP_R      = 6'h00;
  localparam logic [5:0] OP_REGIMM = 6'h01;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_JAL    = 6'h03;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_BLEZ   = 6'h06;
  localparam logic [5:0] OP_BGTZ   = 6'h07;
  localparam logic [5:0] OP_ORI    = 6'h0D;
  localparam logic [5:0] OP_LUI    = 6'h0F;
  localparam logic [5:0] OP_LB     = 6'h20;
  localparam logic [5:0] OP_LH     = 6'h21;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_LBU    = 6'h24;
  localparam logic [5:0] OP_SB     = 6'h28;
  localparam logic [5:0] OP_SH     = 6'h29;
  localparam logic [5:0] OP_SW     = 6'h2B;

  localparam logic [5:0] F_JR    = 6'h08;
  localparam logic [5:0] F_MFHI  = 6'h10;
  localparam logic [5:0] F_MTHI  = 6'h11;
  localparam logic [5:0] F_MFLO  = 6'h12;
  localparam logic [5:0] F_MTLO  = 6'h13;
  localparam logic [5:0] F_MULT  = 6'h18;
  localparam logic [5:0] F_MULTU = 6'h19;
  localparam logic [5:0] F_DIV   = 6'h1A;
  localparam logic [5:0] F_DIVU  = 6'h1B;
  localparam logic [5:0] F_ADD   = 6'h20;
  localparam logic [5:0] F_SUB   = 6'h22;
  localparam logic [5:0] F_OR    = 6'h25;

  logic [5:0]       opcode;
  logic [5:0]       funct;
  logic [4:0]       rt;
  logic             unused_fields;
  ctrl_t            dec;
  ctrl_t            ctrl_next;
  ctrl_t            ctrl_reg;
  logic             known;
  logic             mdu_cls;
  logic             mdu_go;
  logic             issue;
  logic             start_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [CNT_W-1:0] cnt_next;

  assign opcode        = instr_d[31:26];
  assign funct         = instr_d[5:0];
  assign rt            = instr_d[20:16];
  assign unused_fields = ^{instr_d[25:21], instr_d[15:6]};

  always_comb begin
    dec     = '0;
    known   = 1'b0;
    mdu_cls = 1'b0;
    mdu_go  = 1'b0;
    case (opcode)
      OP_R: begin
        case (funct)
          F_ADD, F_SUB, F_OR: begin
            known         = 1'b1;
            dec.reg_write = 1'b1;
            dec.reg_dst   = 2'b01;
            dec.alu_op    = (funct == F_SUB) ? 4'h1 : (funct == F_OR) ? 4'h2 : 4'h0;
          end
          F_JR: begin
            known        = 1'b1;
            dec.jump     = 1'b1;
            dec.jump_src = 2'b10;
          end
          // funct[1:0] orders mult, multu, div, divu onto mdu_op 1..4
          F_MULT, F_MULTU, F_DIV, F_DIVU: begin
            known      = 1'b1;
            mdu_cls    = 1'b1;
            mdu_go     = 1'b1;
            dec.mdu_op = {1'b0, funct[1:0]} + 3'd1;
          end
          F_MTHI, F_MTLO: begin
            known      = 1'b1;
            mdu_cls    = 1'b1;
            dec.mdu_op = funct[1] ? 3'b110 : 3'b101;
          end
          F_MFHI, F_MFLO: begin
            known         = 1'b1;
            mdu_cls       = 1'b1;
            dec.reg_write = 1'b1;
            dec.reg_dst   = 2'b01;
            dec.mem2reg   = 2'b11;
            dec.hilo_sel  = ~funct[1];
          end
          default: ;
        endcase
      end
      OP_REGIMM: begin
        if (rt == 5'd0 || rt == 5'd1) begin
          known      = 1'b1;
          dec.branch = 1'b1;
          dec.ext_op = 2'b10;
          dec.b_op   = rt[0] ? 6'b010000 : 6'b000010;
        end
      end
      OP_J, OP_JAL: begin
        known        = 1'b1;
        dec.jump     = 1'b1;
        dec.jump_src = 2'b01;
        if (opcode == OP_JAL) begin
          dec.reg_write = 1'b1;
          dec.reg_dst   = 2'b11;
          dec.mem2reg   = 2'b10;
        end
      end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: begin
        known      = 1'b1;
        dec.branch = 1'b1;
        dec.ext_op = 2'b10;
        case (opcode)
          OP_BEQ:  dec.b_op = 6'b100000;
          OP_BNE:  dec.b_op = 6'b000001;
          OP_BLEZ: dec.b_op = 6'b000100;
          default: dec.b_op = 6'b001000;
        endcase
      end
      OP_ORI, OP_LUI: begin
        known         = 1'b1;
        dec.reg_write = 1'b1;
        dec.reg_dst   = 2'b10;
        dec.alu_src   = 1'b1;
        dec.ext_op    = (opcode == OP_ORI) ? 2'b01 : 2'b00;
        dec.alu_op    = (opcode == OP_ORI) ? 4'h2 : 4'h3;
      end
      // opcode[3] separates stores (0x28..0x2B) from loads (0x20..0x24)
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_SB, OP_SH, OP_SW: begin
        known       = 1'b1;
        dec.alu_src = 1'b1;
        dec.ext_op  = 2'b10;
        if (opcode[3]) begin
          dec.mem_write = 1'b1;
        end else begin
          dec.reg_write = 1'b1;
          dec.reg_dst   = 2'b10;
          dec.mem2reg   = 2'b01;
        end
        case (opcode)
          OP_LB, OP_SB: dec.ls_type = 2'b01;
          OP_LH, OP_SH: dec.ls_type = 2'b11;
          OP_LBU:       dec.ls_type = 2'b10;
          default:      dec.ls_type = 2'b00;
        endcase
      end
      default: ;
    endcase
    dec.valid = known;
  end

  assign mdu_busy  = (cnt_reg != '0);
  assign stall_out = valid_d & mdu_cls & (mdu_busy | start_reg);
  assign issue     = valid_d & ~flush & ~stall_in & ~stall_out;

  always_comb begin
    ctrl_next = '0;
    if (issue) begin
      if (known) begin
        ctrl_next = dec;
      end
`ifdef ILLEGAL_TRAP_EN
      else begin
        ctrl_next.valid   = 1'b1;
        ctrl_next.illegal = 1'b1;
      end
`endif
    end
  end

  // The bundle issued alongside the start pulse tells mult (op 1,2) from div (op 3,4)
  always_comb begin
    cnt_next = cnt_reg;
    if (start_reg) begin
      cnt_next = (ctrl_reg.mdu_op >= 3'd3) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
    end else if (mdu_busy) begin
      cnt_next = cnt_reg - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ctrl_reg  <= '0;
      start_reg <= 1'b0;
      cnt_reg   <= '0;
    end else begin
      ctrl_reg  <= ctrl_next;
      start_reg <= issue & mdu_go;
      cnt_reg   <= cnt_next;
    end
  end

  assign mdu_start   = start_reg;
  assign e_valid     = ctrl_reg.valid;
  assign e_reg_write = ctrl_reg.reg_write;
  assign e_mem_write = ctrl_reg.mem_write;
  assign e_alu_src   = ctrl_reg.alu_src;
  assign e_branch    = ctrl_reg.branch;
  assign e_jump      = ctrl_reg.jump;
  assign e_reg_dst   = ctrl_reg.reg_dst;
  assign e_mem2reg   = ctrl_reg.mem2reg;
  assign e_ext_op    = ctrl_reg.ext_op;
  assign e_alu_op    = ctrl_reg.alu_op;
  assign e_ls_type   = ctrl_reg.ls_type;
  assign e_b_op      = ctrl_reg.b_op;
  assign e_jump_src  = ctrl_reg.jump_src;
  assign e_mdu_op    = ctrl_reg.mdu_op;
  assign e_hilo_sel  = ctrl_reg.hilo_sel;
  assign e_illegal   = ctrl_reg.illegal;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Randomized bench for decode_ctrl_pipe: table-driven instruction model plus a
// timestamp-based MDU busy model; one line printed per cycle.
module tb_decode_ctrl_pipe;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] instr_d = '0;
  logic        valid_d = 1'b0;
  logic        stall_in = 1'b0;
  logic        flush = 1'b0;
  logic        stall_out, e_valid, e_reg_write, e_mem_write, e_alu_src, e_branch, e_jump;
  logic [1:0]  e_reg_dst, e_mem2reg, e_ext_op, e_ls_type, e_jump_src;
  logic [3:0]  e_alu_op;
  logic [5:0]  e_b_op;
  logic [2:0]  e_mdu_op;
  logic        e_hilo_sel, mdu_start, mdu_busy, e_illegal;

  decode_ctrl_pipe dut (
    .clk(clk), .reset(reset), .instr_d(instr_d), .valid_d(valid_d),
    .stall_in(stall_in), .flush(flush), .stall_out(stall_out),
    .e_valid(e_valid), .e_reg_write(e_reg_write), .e_mem_write(e_mem_write),
    .e_alu_src(e_alu_src), .e_branch(e_branch), .e_jump(e_jump),
    .e_reg_dst(e_reg_dst), .e_mem2reg(e_mem2reg), .e_ext_op(e_ext_op),
    .e_alu_op(e_alu_op), .e_ls_type(e_ls_type), .e_b_op(e_b_op),
    .e_jump_src(e_jump_src), .e_mdu_op(e_mdu_op), .e_hilo_sel(e_hilo_sel),
    .mdu_start(mdu_start), .mdu_busy(mdu_busy), .e_illegal(e_illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic v, rw, mw, asrc, br, jp;
    logic [1:0] rd, m2r, ext;
    logic [3:0] alu;
    logic [1:0] ls;
    logic [5:0] bop;
    logic [1:0] js;
    logic [2:0] mdu;
    logic hs, ill;
  } bundle_t;

  // cls: 0 non-MDU, 1 mult-type start, 2 div-type start, 3 other HI/LO access
  typedef struct {
    logic [5:0] op;
    logic [5:0] key;
    int         cls;
    bundle_t    b;
  } row_t;

  row_t    rows[$];
  int      n_checks = 0;
  int      n_errors = 0;
  int      cyc = 0;
  int      st_cyc = -100;
  int      st_len = 0;
  bundle_t exp_b = '0;
  bit      armed = 1'b0;
  logic    last_stall = 1'b0;
  int      seen_start, seen_busy, seen_stall;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
    n_checks++;
    if (got !== expv) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (cyc %0d)", tag, got, expv, cyc);
    end
  endtask

  function automatic void add_row(input logic [5:0] op, input logic [5:0] key, input int cls,
                                  input logic rw, input logic mw, input logic asrc,
                                  input logic br, input logic jp, input logic [1:0] rd,
                                  input logic [1:0] m2r, input logic [1:0] ext,
                                  input logic [3:0] alu, input logic [1:0] ls,
                                  input logic [5:0] bop, input logic [1:0] js,
                                  input logic [2:0] mdu, input logic hs);
    row_t r;
    r.op = op; r.key = key; r.cls = cls;
    r.b = '0;
    r.b.v = 1'b1; r.b.rw = rw; r.b.mw = mw; r.b.asrc = asrc; r.b.br = br; r.b.jp = jp;
    r.b.rd = rd; r.b.m2r = m2r; r.b.ext = ext; r.b.alu = alu; r.b.ls = ls;
    r.b.bop = bop; r.b.js = js; r.b.mdu = mdu; r.b.hs = hs;
    rows.push_back(r);
  endfunction

  function automatic void build_table();
    //       op     key  cls rw mw as br jp rd     m2r    ext    alu   ls     bop        js     mdu   hs
    add_row(6'h00, 6'h20, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 4'h0, 2'b00, 6'b000000, 2'b00, 3'd0, 0); // add
    add_row(6'h00, 6'h22, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 4'h1, 2'b00, 6'b000000, 2'b00, 3'd0, 0); // sub
    add_row(6'h00, 6'h25, 0, 1, 0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 4'h2, 2'b00, 6'b000000, 2'b00, 3'd0, 0); // or
    add_row(6'h00, 6'h08, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 4'h0, 2'b00, 6'b000000, 2'b10, 3'd0, 0); // jr
    add_row(6'h00, 6'h18, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'h0, 2'b00, 6'b000000, 2'b00, 3'd1, 0); // mult
    add_row(6'h00, 6'h19, 1, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'h0, 2'b00, 6'b000000, 2'b00, 3'd2, 0); // multu
    add_row(6'h00, 6'h1A, 2, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'h0, 2'b00, 6'b000000, 2'b00, 3'd3, 0); // div
    add_row(6'h00, 6'h1B, 2, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'h0, 2'b00, 6'b000000, 2'b00, 3'd4, 0); // divu
    add_row(6'h00, 6'h11, 3, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'h0, 2'b00, 6'b000000, 2'b00, 3'd5, 0); // mthi
    add_row(6'h00, 6'h13, 3, 0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 4'h0, 2'b00, 6'b000000, 2'b00, 3'd6, 0); // mtlo
    add_row(6'h00, 6'h10, 3, 1, 0, 0, 0, 0, 2'b01, 2'b11, 2'b00, 4'h0, 2'b00, 6'b000000, 2'b00, 3'd0, 1); // mfhi
    add_row(6'h00, 6'h12, 3, 1, 0, 0, 0, 0, 2'b01, 2'b11, 2'b00, 4'h0, 2'b00, 6'b000000, 2'b00, 3'd0, 0); // mflo
    add_row(6'h01, 6'h01, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b10, 4'h0, 2'b00, 6'b010000, 2'b00, 3'd0, 0); // bgez
    add_row(6'h01, 6'h00, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b10, 4'h0, 2'b00, 6'b000010, 2'b00, 3'd0, 0); // bltz
    add_row(6'h02, 6'h00, 0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, 4'h0, 2'b00, 6'b000000, 2'b01, 3'd0, 0); // j
    add_row(6'h03, 6'h00, 0, 1, 0, 0, 0, 1, 2'b11, 2'b10, 2'b00, 4'h0, 2'b00, 6'b000000, 2'b01, 3'd0, 0); // jal
    add_row(6'h04, 6'h00, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b10, 4'h0, 2'b00, 6'b100000, 2'b00, 3'd0, 0); // beq
    add_row(6'h05, 6'h00, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b10, 4'h0, 2'b00, 6'b000001, 2'b00, 3'd0, 0); // bne
    add_row(6'h06, 6'h00, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b10, 4'h0, 2'b00, 6'b000100, 2'b00, 3'd0, 0); // blez
    add_row(6'h07, 6'h00, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b10, 4'h0, 2'b00, 6'b001000, 2'b00, 3'd0, 0); // bgtz
    add_row(6'h0D, 6'h00, 0, 1, 0, 1, 0, 0, 2'b10, 2'b00, 2'b01, 4'h2, 2'b00, 6'b000000, 2'b00, 3'd0, 0); // ori
    add_row(6'h0F, 6'h00, 0, 1, 0, 1, 0, 0, 2'b10, 2'b00, 2'b00, 4'h3, 2'b00, 6'b000000, 2'b00, 3'd0, 0); // lui
    add_row(6'h20, 6'h00, 0, 1, 0, 1, 0, 0, 2'b10, 2'b01, 2'b10, 4'h0, 2'b01, 6'b000000, 2'b00, 3'd0, 0); // lb
    add_row(6'h21, 6'h00, 0, 1, 0, 1, 0, 0, 2'b10, 2'b01, 2'b10, 4'h0, 2'b11, 6'b000000, 2'b00, 3'd0, 0); // lh
    add_row(6'h23, 6'h00, 0, 1, 0, 1, 0, 0, 2'b10, 2'b01, 2'b10, 4'h0, 2'b00, 6'b000000, 2'b00, 3'd0, 0); // lw
    add_row(6'h24, 6'h00, 0, 1, 0, 1, 0, 0, 2'b10, 2'b01, 2'b10, 4'h0, 2'b10, 6'b000000, 2'b00, 3'd0, 0); // lbu
    add_row(6'h28, 6'h00, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b10, 4'h0, 2'b01, 6'b000000, 2'b00, 3'd0, 0); // sb
    add_row(6'h29, 6'h00, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b10, 4'h0, 2'b11, 6'b000000, 2'b00, 3'd0, 0); // sh
    add_row(6'h2B, 6'h00, 0, 0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b10, 4'h0, 2'b00, 6'b000000, 2'b00, 3'd0, 0); // sw
  endfunction

  function automatic int find(input logic [31:0] w);
    for (int i = 0; i < rows.size(); i++) begin
      if (w[31:26] == rows[i].op) begin
        if (rows[i].op == 6'h00) begin
          if (w[5:0] == rows[i].key) return i;
        end else if (rows[i].op == 6'h01) begin
          if ({1'b0, w[20:16]} == rows[i].key) return i;
        end else begin
          return i;
        end
      end
    end
    return -1;
  endfunction

  function automatic logic [31:0] make_instr(input int i);
    logic [31:0] w;
    w = $urandom;
    w[31:26] = rows[i].op;
    if (rows[i].op == 6'h00) w[5:0] = rows[i].key;
    if (rows[i].op == 6'h01) w[20:16] = rows[i].key[4:0];
    return w;
  endfunction

  task automatic drive(input logic [31:0] w, input logic v, input logic fl,
                       input logic si, input logic rs);
    instr_d = w; valid_d = v; flush = fl; stall_in = si; reset = rs;
  endtask

  // One cycle: check outputs mid-cycle, predict the next edge, advance the clock.
  task automatic step();
    bundle_t got;
    int      r;
    logic    exp_start, exp_busy, exp_stall, issue;
    @(negedge clk);
    r = find(instr_d);
    exp_start = (cyc == st_cyc);
    exp_busy  = (cyc > st_cyc) && (cyc <= st_cyc + st_len);
    exp_stall = valid_d && (r >= 0) && (rows[r].cls != 0) && (exp_start || exp_busy);
    got = {e_valid, e_reg_write, e_mem_write, e_alu_src, e_branch, e_jump, e_reg_dst,
           e_mem2reg, e_ext_op, e_alu_op, e_ls_type, e_b_op, e_jump_src, e_mdu_op,
           e_hilo_sel, e_illegal};
    if (armed) begin
      check("bundle", got, exp_b);
      check("mdu_start", mdu_start, exp_start);
      check("mdu_busy", mdu_busy, exp_busy);
      check("stall_out", stall_out, exp_stall);
    end
    last_stall = stall_out;
    seen_start += int'(mdu_start);
    seen_busy  += int'(mdu_busy);
    seen_stall += int'(stall_out);
    issue = valid_d && !flush && !stall_in && !exp_stall;
    $display("cyc %0d instr=%h v=%b fl=%b si=%b rst=%b stall=%b busy=%b start=%b e=%h",
             cyc, instr_d, valid_d, flush, stall_in, reset, stall_out, mdu_busy, mdu_start, got);
    if (!reset) begin
      exp_b  = '0;
      st_cyc = -100;
    end else begin
      exp_b = '0;
      if (issue && r >= 0) begin
        exp_b = rows[r].b;
        if (rows[r].cls == 1 || rows[r].cls == 2) begin
          st_cyc = cyc + 1;
          st_len = (rows[r].cls == 1) ? 5 : 10;
        end
      end
`ifdef ILLEGAL_TRAP_EN
      else if (issue) begin
        exp_b.v   = 1'b1;
        exp_b.ill = 1'b1;
      end
`endif
    end
    @(posedge clk);
    cyc++;
    armed = 1'b1;
    #1;
  endtask

  localparam logic [31:0] I_ADD  = 32'h00221820;
  localparam logic [31:0] I_MULT = 32'h00220018;
  localparam logic [31:0] I_MFLO = 32'h00001812;
  localparam logic [31:0] I_MFHI = 32'h00001810;
  localparam logic [31:0] I_DIV  = 32'h0022001A;
  localparam logic [31:0] I_ORI  = 32'h34220005;
  localparam logic [31:0] I_BEQ  = 32'h10220004;

  initial begin
    int n;
    build_table();

    drive(I_ADD, 1, 0, 0, 0);
    step(); step();
    check("rst_e_valid", e_valid, 0);
    check("rst_reg_write", e_reg_write, 0);
    check("rst_busy", mdu_busy, 0);

    drive(I_ADD, 1, 0, 0, 1);
    step();
    check("add_valid", e_valid, 1);
    check("add_reg_dst", e_reg_dst, 2'b01);
    check("add_reg_write", e_reg_write, 1);
    check("add_alu_op", e_alu_op, 4'h0);

    drive(I_MULT, 1, 0, 0, 1);
    step();
    seen_start = 0; seen_busy = 0; seen_stall = 0;
    drive(I_MFLO, 1, 0, 0, 1);
    n = 0;
    do begin
      step();
      n++;
    end while (last_stall && n < 20);
    check("mflo_stall_cycles", seen_stall, 6);
    check("mult_start_pulses", seen_start, 1);
    check("mult_busy_cycles", seen_busy, 5);
    check("mflo_mem2reg", e_mem2reg, 2'b11);
    check("mflo_hilo_sel", e_hilo_sel, 0);

    drive(I_DIV, 1, 0, 0, 1);
    step();
    drive(I_ORI, 1, 0, 0, 1);
    step();
    check("ori_no_stall", last_stall, 0);
    check("ori_valid", e_valid, 1);
    check("ori_ext_op", e_ext_op, 2'b01);
    drive(32'h0, 0, 0, 0, 1);
    for (int i = 0; i < 12; i++) step();

    drive(I_DIV, 1, 0, 0, 1);
    step();
    drive(32'h0, 0, 0, 0, 1);
    for (int i = 0; i < 7; i++) step();
    check("div_busy_before_rst", mdu_busy, 1);
    drive(32'h0, 0, 0, 0, 0);
    step();
    check("div_rst_busy", mdu_busy, 0);
    drive(I_MFHI, 1, 0, 0, 1);
    step();
    check("mfhi_no_stall", last_stall, 0);
    check("mfhi_valid", e_valid, 1);
    check("mfhi_hilo_sel", e_hilo_sel, 1);

    drive(I_BEQ, 1, 1, 1, 1);
    step();
    check("flush_valid", e_valid, 0);
    check("flush_branch", e_branch, 0);

`ifdef ILLEGAL_TRAP_EN
    drive(32'hFC000000, 1, 0, 0, 1);
    step();
    check("illegal_flag", e_illegal, 1);
    check("illegal_valid", e_valid, 1);
`endif

    for (int k = 0; k < 800; k++) begin
      logic [31:0] w;
      if ($urandom_range(3) != 0) w = make_instr(int'($urandom_range(rows.size() - 1)));
      else w = $urandom;
      drive(w, $urandom_range(7) != 0, $urandom_range(9) == 0,
            $urandom_range(7) == 0, $urandom_range(63) != 0);
      step();
    end
    drive(32'h0, 0, 0, 0, 1);
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
